// File: rtl/bsg_manycore_trace_pkg.sv
// Shared definitions for the vanilla-core trace-window controller.
// The pattern localparams double as the encodings emitted by the software trigger macros.
package bsg_manycore_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } trace_window_state_e;

  // addi x0,x0,0 and addi x1,x0,0 style no-ops used as start/end markers.
  localparam logic [31:0] trace_start_pattern_gp = 32'h0000_0013;
  localparam logic [31:0] trace_end_pattern_gp   = 32'h0000_0093;
  localparam logic [31:0] trace_pattern_mask_gp  = 32'hFFFF_FFFF;

endpackage

// File: rtl/vanilla_core_trace_window_chan.sv
// One monitored core: masked start/end trigger match plus its active bit.
// Updates apply only while en_i is high; clear_i forces the bit low and wins over triggers.
module vanilla_core_trace_window_chan
  import bsg_manycore_trace_pkg::*;
#(
  parameter int unsigned              data_width_p    = 32,
  parameter logic [data_width_p-1:0]  start_pattern_p = data_width_p'(trace_start_pattern_gp),
  parameter logic [data_width_p-1:0]  end_pattern_p   = data_width_p'(trace_end_pattern_gp),
  parameter logic [data_width_p-1:0]  pattern_mask_p  = data_width_p'(trace_pattern_mask_gp)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    instr_v_i,
  input  logic [data_width_p-1:0] instr_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  output logic                    start_o,
  output logic                    end_o,
  output logic                    active_next_o,
  output logic                    active_o
);

  logic active_q, active_d;

  assign start_o = instr_v_i & ((instr_i & pattern_mask_p) == (start_pattern_p & pattern_mask_p));
  assign end_o   = instr_v_i & ((instr_i & pattern_mask_p) == (end_pattern_p & pattern_mask_p));

  // Next active bit: end beats start on the same channel.
  always_comb begin
    active_d = active_q;
    if (clear_i) begin
      active_d = 1'b0;
    end else if (en_i) begin
      if (end_o) begin
        active_d = 1'b0;
      end else if (start_o) begin
        active_d = 1'b1;
      end
    end
  end

  // Active bit register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  assign active_next_o = active_d;
  assign active_o      = active_q;

endmodule

// File: rtl/vanilla_core_trace_window_ctrl.sv
// Global measurement-window controller across a group of vanilla cores.
// A window is open while any core is active; on close a report (id, length) is handed off
// over valid/ready. Optional forced close after a cycle limit: BSG_TRACE_WINDOW_TIMEOUT_EN.
module vanilla_core_trace_window_ctrl
  import bsg_manycore_trace_pkg::*;
#(
  parameter int unsigned              num_channels_p  = 4,
  parameter int unsigned              data_width_p    = 32,
  parameter logic [data_width_p-1:0]  start_pattern_p = data_width_p'(trace_start_pattern_gp),
  parameter logic [data_width_p-1:0]  end_pattern_p   = data_width_p'(trace_end_pattern_gp),
  parameter logic [data_width_p-1:0]  pattern_mask_p  = data_width_p'(trace_pattern_mask_gp),
  parameter int unsigned              cycle_width_p   = 32,
  parameter int unsigned              max_windows_p   = 8
`ifdef BSG_TRACE_WINDOW_TIMEOUT_EN
  , parameter int unsigned            timeout_cycles_p = 1024
`endif
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_channels_p-1:0]              instr_v_i,
  input  logic [num_channels_p*data_width_p-1:0] instr_i,
  output logic                                   window_en_o,
  output logic [num_channels_p-1:0]              active_mask_o,
  output logic                                   report_v_o,
  input  logic                                   report_ready_i,
  output logic [$clog2(max_windows_p+1)-1:0]     report_id_o,
  output logic [cycle_width_p-1:0]               report_cycles_o,
`ifdef BSG_TRACE_WINDOW_TIMEOUT_EN
  output logic                                   timeout_o,
`endif
  output logic                                   dropped_o,
  output logic                                   done_o
);

  localparam int unsigned IdWidth = $clog2(max_windows_p + 1);

  trace_window_state_e       state_q, state_d;
  logic [cycle_width_p-1:0]  cnt_q, cnt_d;
  logic [IdWidth-1:0]        id_q, id_d;
  logic                      dropped_q, dropped_d;
  logic [num_channels_p-1:0] start_li, end_li, active_next_li;
  logic                      chan_en, chan_clear, timeout_fire, handshake, ignoring;

`ifdef BSG_TRACE_WINDOW_TIMEOUT_EN
  logic timeout_q;
  assign timeout_fire = (state_q == ACTIVE) && (cnt_q == cycle_width_p'(timeout_cycles_p));

  // Sticky timeout flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timeout_q <= 1'b0;
    end else if (timeout_fire) begin
      timeout_q <= 1'b1;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_fire = 1'b0;
`endif

  assign ignoring   = (state_q == DRAIN) || (state_q == DONE);
  assign chan_en    = (state_q == IDLE) || (state_q == ACTIVE);
  assign chan_clear = ignoring || timeout_fire;
  assign handshake  = report_v_o & report_ready_i;

  for (genvar i = 0; i < num_channels_p; i++) begin : g_chan
    vanilla_core_trace_window_chan #(
      .data_width_p    (data_width_p),
      .start_pattern_p (start_pattern_p),
      .end_pattern_p   (end_pattern_p),
      .pattern_mask_p  (pattern_mask_p)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .instr_v_i     (instr_v_i[i]),
      .instr_i       (instr_i[i*data_width_p +: data_width_p]),
      .en_i          (chan_en),
      .clear_i       (chan_clear),
      .start_o       (start_li[i]),
      .end_o         (end_li[i]),
      .active_next_o (active_next_li[i]),
      .active_o      (active_mask_o[i])
    );
  end

  // State, counter, id and sticky-drop registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      id_q      <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state logic; a timeout empties the mask via chan_clear, so it closes like a last end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    dropped_d = dropped_q | (ignoring & (|(start_li | end_li)));
    unique case (state_q)
      IDLE: begin
        if (|active_next_li) begin
          state_d = ACTIVE;
          cnt_d   = cycle_width_p'(1);
        end
      end
      ACTIVE: begin
        if (active_next_li == '0) begin
          state_d = DRAIN;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + cycle_width_p'(1);
        end
      end
      DRAIN: begin
        if (handshake) begin
          id_d    = id_q + IdWidth'(1);
          state_d = (id_d == IdWidth'(max_windows_p)) ? DONE : IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    window_en_o     = (state_q == ACTIVE);
    report_v_o      = (state_q == DRAIN);
    done_o          = (state_q == DONE);
    report_id_o     = id_q;
    report_cycles_o = cnt_q;
    dropped_o       = dropped_q;
  end

endmodule

// File: doc/vanilla_core_trace_window_ctrl.md
Name: vanilla_core_trace_window_ctrl

Overview:
Multi-channel measurement-window controller for a group of vanilla cores, placed in the testbench beside the tiles. It watches each core's executing instruction for start/end trigger encodings and keeps a per-core active bit. One global window is open while any core is active. When the window closes, it issues a report request over a valid/ready handshake, carrying the window id and the length in cycles, so the toggle-capture/report layer can act once per window.

Parameters:
num_channels_p, 4, number of cores monitored (>=1)
data_width_p, 32, instruction width
start_pattern_p, 32'h0000_0013, start trigger encoding
end_pattern_p, 32'h0000_0093, end trigger encoding
pattern_mask_p, 32'hFFFF_FFFF, bit=1 compared, bit=0 don't-care
cycle_width_p, 32, window cycle-counter width
max_windows_p, 8, windows reported before block goes DONE
timeout_cycles_p, 1024, forced-close limit (only with optional feature)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
instr_v_i  in  num_channels_p  per-channel instruction valid in EXE
instr_i  in  num_channels_p*data_width_p  per-channel EXE instruction; channel i at [i*data_width_p +: data_width_p]
window_en_o  out  1  window open (toggle capture on)
active_mask_o  out  num_channels_p  per-channel active bits
report_v_o  out  1  report request valid
report_ready_i  in  1  report consumer ready
report_id_o  out  clog2(max_windows_p+1)  id of window being reported
report_cycles_o  out  cycle_width_p  length of closed window
dropped_o  out  1  sticky: trigger ignored in DRAIN/DONE
done_o  out  1  max_windows_p windows reported

Behaviour:
- Clock and reset: one clock (clk_i). reset_i is asynchronous and active-high.
- Reset values: all outputs 0. State IDLE, counters 0.
- Match rule: start_i = instr_v_i[i] & ((instr & mask) == (start_pattern_p & mask)). end_i uses end_pattern_p the same way.
  - If start_i and end_i both match on one channel, end wins.
- Per-channel bit (IDLE/ACTIVE only):
  - start_i sets the bit; end_i clears it.
  - Redundant start on an active channel: no effect.
  - End on an inactive channel: no effect.
  - Different channels may start and end in the same cycle; all updates apply.
- FSM, all outputs registered:
  - IDLE: any start_i -> ACTIVE next cycle. Cycle counter loads 1. window_en_o=1 from that cycle.
  - ACTIVE: counter increments each cycle and saturates at all-ones. When the next-state active_mask is 0 -> DRAIN.
    - window_en_o drops in the DRAIN entry cycle.
    - If one channel ends while another starts in the same cycle, the mask stays nonzero and the window stays open.
  - DRAIN:
    - report_v_o=1, with report_id_o and report_cycles_o held stable until the handshake.
    - Handshake occurs when report_v_o & report_ready_i. On it, the id increments. If id+1 == max_windows_p -> DONE, else IDLE.
    - report_v_o never drops without a handshake.
    - Triggers here are ignored and set dropped_o.
  - DONE: done_o=1, window_en_o=0. Triggers ignored and set dropped_o. Exits only on reset.
- Latency: trigger in cycle N -> window_en_o in N+1. Last end in cycle M -> report_v_o in M+1.
- Reset mid-window or mid-DRAIN: immediate return to reset values. No report is issued for the aborted window.

Optional Feature:
BSG_TRACE_WINDOW_TIMEOUT_EN
- Defined: in ACTIVE, when the counter reaches timeout_cycles_p, the block enters DRAIN the next cycle, clears all active bits, and sets sticky bit 0 of an extra output timeout_o.
- Undefined: no timeout logic and no timeout_o port. Windows close only on end triggers.

Decomposition:
- Shared package bsg_manycore_trace_pkg holds:
  - typedef enum trace_window_state_e {IDLE, ACTIVE, DRAIN, DONE}
  - default start/end pattern and mask localparams, also used by software trigger macros.
- Sub-module vanilla_core_trace_window_chan, one instance per channel: pattern match plus active bit, with a clear input driven in DRAIN/timeout.

Test Plan:
- ch0 start at cycle 10, ch0 end at cycle 20 -> window_en_o high cycles 11-20; report_v_o at 21 with cycles=10, id=0; ready at 23 -> IDLE at 24.
- ch1 start @5, ch2 start @8, ch1 end @12, ch2 end @15 -> one window, active_mask 0010->0110->0100->0000, cycles=10.
- Same cycle: ch0 end and ch3 start while ch0 is the only active channel -> window stays open, no report.
- report_ready_i held 0 for 50 cycles, ch0 start during DRAIN -> report fields stable, dropped_o=1, active_mask unchanged.
- max_windows_p=2: two full windows -> done_o=1 after second handshake; further start -> window_en_o stays 0, dropped_o=1.
- reset_i pulsed asynchronously mid-ACTIVE -> all outputs 0 immediately, next start opens window with id 0. With BSG_TRACE_WINDOW_TIMEOUT_EN and timeout_cycles_p=16: start, no end -> report_cycles_o=16, timeout_o=1.
